regfile_ran_arbiter: RTL and testbench

//  Shares the regfile random-access port (ran_we/ran_re) among NUM_REQ requesters.

---
 rtl/regfile_ran_arbiter.sv | 160 ++++++++++++++++
 tb/tb_regfile_ran_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_ran_arbiter.sv
// Round-robin burst arbiter sharing the regfile random-access port among NUM_REQ clients.
// Optional REGFILE_ARB_PRIO0_EN: requester 0 wins every idle arbitration it takes part in.
module regfile_ran_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MAX_BURST  = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            rvalid,
   output logic [DATA_WIDTH-1:0]         rdata,
   output logic                          ran_we,
   output logic [ADDR_WIDTH-1:0]         ran_w_addr,
   output logic [DATA_WIDTH-1:0]         ran_w_data,
   output logic                          ran_re,
   output logic [ADDR_WIDTH-1:0]         ran_r_addr,
   input  logic [DATA_WIDTH-1:0]         ran_r_data
);

   localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CW = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                  state_q, state_d;
   logic [PW-1:0]           ptr_q, ptr_d;
   logic [PW-1:0]           owner_q, owner_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [NUM_REQ-1:0]      gnt_d;
   logic [NUM_REQ-1:0]      rvalid_d;
   logic [DATA_WIDTH-1:0]   rdata_q;

   logic                    owner_req;
   logic                    owner_we;
   logic                    owner_last;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [DATA_WIDTH-1:0]   sel_wdata;
   logic                    fire;
   logic                    win_found;
   logic [PW-1:0]           win;

   // Mux the current owner's beat fields
   always_comb begin
      owner_req  = 1'b0;
      owner_we   = 1'b0;
      owner_last = 1'b0;
      sel_addr   = '0;
      sel_wdata  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (owner_q == PW'(i)) begin
            owner_req  = req[i];
            owner_we   = req_we[i];
            owner_last = req_last[i];
            sel_addr   = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata  = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Beat goes straight to the regfile in the cycle it is accepted
   always_comb begin
      fire       = (state_q == BUSY) && owner_req;
      ran_we     = fire && owner_we;
      ran_re     = fire && !owner_we;
      ran_w_addr = ran_we ? sel_addr  : '0;
      ran_w_data = ran_we ? sel_wdata : '0;
      ran_r_addr = ran_re ? sel_addr  : '0;
   end

   // Winner search starting at ptr, wrapping modulo NUM_REQ
   always_comb begin
      int unsigned idx;
      win_found = 1'b0;
      win       = '0;
      idx       = 0;
`ifdef REGFILE_ARB_PRIO0_EN
      if (req[0]) begin
         win_found = 1'b1;
         win       = '0;
      end
`endif
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = (32'(ptr_q) + i) % NUM_REQ;
         if (!win_found && req[idx]) begin
            win_found = 1'b1;
            win       = PW'(idx);
         end
      end
   end

   // Next-state, grant and read-return tag
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      cnt_d    = cnt_q;
      gnt_d    = gnt;
      rvalid_d = '0;
      if (ran_re) begin
         rvalid_d = NUM_REQ'(1) << owner_q;
      end
      case (state_q)
         IDLE: begin
            gnt_d = '0;
            if (win_found) begin
               state_d = BUSY;
               owner_d = win;
               gnt_d   = NUM_REQ'(1) << win;
            end
         end
         BUSY: begin
            if (!owner_req || owner_last || (cnt_q == CW'(MAX_BURST - 1))) begin
               state_d = IDLE;
               ptr_d   = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);
               cnt_d   = '0;
               gnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
         gnt     <= '0;
         rvalid  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         gnt     <= gnt_d;
         rvalid  <= rvalid_d;
         if (|rvalid) begin
            rdata_q <= ran_r_data;
         end
      end
   end

   // Regfile data is valid in the rvalid cycle; hold it afterwards
   assign rdata = (|rvalid) ? ran_r_data : rdata_q;

endmodule

// File: tb/tb_regfile_ran_arbiter.sv
// Scoreboard bench for regfile_ran_arbiter: directed bursts, expected beats/returns queued at issue.
module tb_regfile_ran_arbiter;
   localparam int unsigned NR = 4;
   localparam int unsigned AW = 12;
   localparam int unsigned DW = 8;
   localparam int unsigned MB = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NR-1:0]     req, req_we, req_last;
   logic [NR*AW-1:0]  req_addr;
   logic [NR*DW-1:0]  req_wdata;
   logic [NR-1:0]     gnt, rvalid;
   logic [DW-1:0]     rdata;
   logic              ran_we, ran_re;
   logic [AW-1:0]     ran_w_addr, ran_r_addr;
   logic [DW-1:0]     ran_w_data, ran_r_data;

   logic              r_req   [NR];
   logic              r_we    [NR];
   logic              r_last  [NR];
   logic [AW-1:0]     r_addr  [NR];
   logic [DW-1:0]     r_wdata [NR];

   typedef struct {int id; logic we; logic [AW-1:0] addr; logic [DW-1:0] data;} beat_t;
   typedef struct {int id; logic [DW-1:0] data;} ret_t;
   beat_t exp_beats[$];
   ret_t  exp_rets[$];
   int    grant_log[$];
   int    grant_cyc[$];
   int    cyc = 0;
   int    n_pass = 0;
   int    n_total = 0;

   logic [DW-1:0] mem [0:4095];

   regfile_ran_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_last(req_last),
      .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .ran_we(ran_we), .ran_w_addr(ran_w_addr), .ran_w_data(ran_w_data),
      .ran_re(ran_re), .ran_r_addr(ran_r_addr), .ran_r_data(ran_r_data)
   );

   always #5 clk = ~clk;

   always_comb begin
      req = '0; req_we = '0; req_last = '0; req_addr = '0; req_wdata = '0;
      for (int i = 0; i < NR; i++) begin
         req[i]                = r_req[i];
         req_we[i]             = r_we[i];
         req_last[i]           = r_last[i];
         req_addr[i*AW +: AW]  = r_addr[i];
         req_wdata[i*DW +: DW] = r_wdata[i];
      end
   end

   // Regfile model: mem[a] preloads to a+0x30; read data is junk unless a read was issued
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int a = 0; a < 4096; a++) mem[a] <= DW'(a + 'h30);
         ran_r_data <= '0;
      end else begin
         if (ran_we) mem[ran_w_addr] <= ran_w_data;
         ran_r_data <= ran_re ? mem[ran_r_addr] : 8'hEE;
      end
   end

   initial forever @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: pops scoreboard entries whenever the DUT shows a beat or a read return
   initial begin
      logic [NR-1:0] exp_rv, prev_rv, prev_gnt, nxt_rv;
      logic [DW-1:0] last_rd;
      int owner, idx, rown;
      beat_t b;
      ret_t  r;
      exp_rv = '0; prev_rv = '0; prev_gnt = '0; last_rd = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_rv = '0; prev_rv = '0; prev_gnt = '0;
         end else begin
            owner = -1;
            for (int j = 0; j < NR; j++) if (gnt[j]) owner = j;
            if (prev_gnt == '0 && gnt != '0) begin
               grant_log.push_back(owner);
               grant_cyc.push_back(cyc);
            end
            nxt_rv = '0;
            if (ran_we || ran_re) begin
               check("beat_excl", 32'(ran_we & ran_re), 32'h0);
               check("beat_gnt_onehot", 32'($countones(gnt)), 32'h1);
               idx = -1;
               for (int j = 0; j < exp_beats.size(); j++)
                  if (idx < 0 && exp_beats[j].id == owner) idx = j;
               if (idx < 0) begin
                  n_total++;
                  $display("FAIL beat_unexpected: owner %0d we %0b, no beat expected (cycle %0d)",
                           owner, ran_we, cyc);
               end else begin
                  b = exp_beats[idx];
                  exp_beats.delete(idx);
                  check("beat_we", 32'(ran_we), 32'(b.we));
                  check("beat_addr", 32'(ran_we ? ran_w_addr : ran_r_addr), 32'(b.addr));
                  if (b.we) check("beat_wdata", 32'(ran_w_data), 32'(b.data));
                  else nxt_rv = NR'(1) << b.id;
               end
            end
            if (exp_rv != '0 || rvalid != '0) check("rvalid", 32'(rvalid), 32'(exp_rv));
            if (rvalid != '0) begin
               rown = -1;
               for (int j = 0; j < NR; j++) if (rvalid[j]) rown = j;
               idx = -1;
               for (int j = 0; j < exp_rets.size(); j++)
                  if (idx < 0 && exp_rets[j].id == rown) idx = j;
               if (idx < 0) begin
                  n_total++;
                  $display("FAIL ret_unexpected: rvalid %b rdata %0h, no return expected", rvalid, rdata);
               end else begin
                  r = exp_rets[idx];
                  exp_rets.delete(idx);
                  check("rdata", 32'(rdata), 32'(r.data));
               end
            end
            if (prev_rv != '0 && rvalid == '0) check("rdata_hold", 32'(rdata), 32'(last_rd));
            if (rvalid != '0) last_rd = rdata;
            prev_rv  = rvalid;
            exp_rv   = nxt_rv;
            prev_gnt = gnt;
         end
      end
   end

   // One requester burst: queues expectations, then holds req until every beat is accepted
   task automatic burst(input int i, input logic we, input logic [AW-1:0] base, input int n,
                        input logic [DW-1:0] xb);
      int k = 0;
      int t = 0;
      logic g;
      beat_t b;
      ret_t  r;
      for (int j = 0; j < n; j++) begin
         b.id = i; b.we = we; b.addr = base + AW'(j); b.data = xb + DW'(j);
         exp_beats.push_back(b);
         if (!we) begin
            r.id = i; r.data = xb + DW'(j);
            exp_rets.push_back(r);
         end
      end
      r_req[i] = 1'b1; r_we[i] = we; r_addr[i] = base; r_wdata[i] = xb; r_last[i] = (n == 1);
      while (k < n && t < 200) begin
         @(negedge clk); g = gnt[i];
         @(posedge clk); #1; t++;
         if (g) begin
            k++;
            if (k < n) begin
               r_addr[i] = base + AW'(k); r_wdata[i] = xb + DW'(k); r_last[i] = (k == n - 1);
            end
         end
      end
      r_req[i] = 1'b0; r_last[i] = 1'b0;
      if (k < n) begin
         n_total++;
         $display("FAIL burst_timeout: req %0d completed %0d of %0d beats", i, k, n);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      beat_t b;
      ret_t  r;
      int    t;
      for (int i = 0; i < NR; i++) begin
         r_req[i] = 1'b1; r_we[i] = 1'b0; r_last[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0;
      end
      // Reset held with every requester asserting
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("reset_quiet", 32'({gnt, rvalid, ran_we, ran_re, rdata}), 32'h0);
      end
      for (int i = 0; i < NR; i++) r_req[i] = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Round-robin from ptr=0: 0,1,2,3,0 with one idle cycle between grants
      grant_log.delete(); grant_cyc.delete();
      fork
         begin burst(0, 1'b1, 12'h040, 1, 8'h11); burst(0, 1'b1, 12'h041, 1, 8'h12); end
         burst(1, 1'b0, 12'h050, 1, 8'h80);
         burst(2, 1'b1, 12'h060, 1, 8'h22);
         burst(3, 1'b0, 12'h070, 1, 8'hA0);
      join
      idle(3);
      check("rr_grants", 32'(grant_log.size()), 32'd5);
      if (grant_log.size() == 5) begin
         check("rr_order", {8'(grant_log[0]), 8'(grant_log[1]), 8'(grant_log[2]), 8'(grant_log[3])},
               32'h00010203);
         check("rr_order_wrap", 32'(grant_log[4]), 32'd0);
         for (int j = 1; j < 5; j++) check("rr_gap", 32'(grant_cyc[j] - grant_cyc[j-1]), 32'd2);
      end

      // Single write by requester 1 (ptr=1): grant in 2nd cycle, one write beat
      fork
         burst(1, 1'b1, 12'h005, 1, 8'hA5);
         begin
            @(negedge clk); check("wr_gnt_idle", 32'(gnt), 32'h0);
            @(negedge clk); check("wr_gnt", 32'(gnt), 32'h2);
            check("wr_we", 32'(ran_we), 32'h1);
            @(negedge clk); check("wr_one_beat", 32'({gnt, ran_we}), 32'h0);
         end
      join
      idle(2);
      check("wr_mem", 32'(mem[12'h005]), 32'hA5);

      // Read burst by requester 2 at 0x010..0x012 -> 0x40,0x41,0x42 under one grant
      grant_log.delete(); grant_cyc.delete();
      burst(2, 1'b0, 12'h010, 3, 8'h40);
      idle(3);
      check("rd_single_grant", 32'(grant_log.size()), 32'd1);

      // Forced release after MB beats: 3 (4 beats), 0, 1, then 3 finishes its last 2
      grant_log.delete(); grant_cyc.delete();
      fork
         burst(3, 1'b1, 12'h100, 6, 8'h60);
         burst(0, 1'b0, 12'h020, 1, 8'h50);
         burst(1, 1'b1, 12'h200, 1, 8'h77);
      join
      idle(3);
      check("mb_grants", 32'(grant_log.size()), 32'd4);
      if (grant_log.size() == 4)
         check("mb_order", {8'(grant_log[0]), 8'(grant_log[1]), 8'(grant_log[2]), 8'(grant_log[3])},
               32'h03000103);
      check("mb_last_beat_mem", 32'(mem[12'h105]), 32'h65);

      // Abort: requester 0 drops req after one read beat (ptr=0)
      b.id = 0; b.we = 1'b0; b.addr = 12'h011; b.data = 8'h41;
      exp_beats.push_back(b);
      r.id = 0; r.data = 8'h41;
      exp_rets.push_back(r);
      r_req[0] = 1'b1; r_we[0] = 1'b0; r_addr[0] = 12'h011; r_last[0] = 1'b0;
      t = 0;
      do begin @(negedge clk); t++; end while (!gnt[0] && t < 20);
      check("abort_gnt", 32'(gnt), 32'h1);
      @(posedge clk); #1; r_req[0] = 1'b0;
      @(negedge clk);
      check("abort_gnt_hold", 32'(gnt), 32'h1);
      check("abort_no_beat", 32'({ran_re, ran_we}), 32'h0);
      @(negedge clk);
      check("abort_idle", 32'(gnt), 32'h0);
      @(posedge clk); #1;

      // Move ptr to 3, then requesters 0 and 3 together
      burst(2, 1'b1, 12'h300, 1, 8'h99);
      idle(2);
      grant_log.delete(); grant_cyc.delete();
      fork
         burst(0, 1'b0, 12'h030, 1, 8'h60);
         burst(3, 1'b1, 12'h301, 1, 8'h9A);
      join
      idle(3);
      check("prio_grants", 32'(grant_log.size()), 32'd2);
      if (grant_log.size() == 2)
`ifdef REGFILE_ARB_PRIO0_EN
         check("prio_order", {8'(grant_log[0]), 8'(grant_log[1])}, 32'h0003);
`else
         check("prio_order", {8'(grant_log[0]), 8'(grant_log[1])}, 32'h0300);
`endif

      idle(4);
      check("sb_beats_empty", 32'(exp_beats.size()), 32'd0);
      check("sb_rets_empty", 32'(exp_rets.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
